// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: frames a byte stream (A5, N, 4*N data bytes, XOR checksum),
// writes big-endian 32-bit words to consecutive addresses and releases the CPU reset on a clean load.
module imem_loader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                run_q;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          csum_q, csum_d;
    logic [WIDTH-9:0]    shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;

    logic                accept;
    logic                len_bad;
    logic [ADDR_W:0]     word_inc;

    assign accept   = rx_valid & rx_ready;
    assign len_bad  = (rx_data == 8'h00) || (int'(rx_data) > DEPTH);
    assign word_inc = word_cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        csum_d     = csum_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_SYNC: begin
                if (accept && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        state_d = S_ERR;
                    end else begin
                        len_d      = rx_data[ADDR_W:0];
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        csum_d     = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; the three earlier bytes sit in shift_q.
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = {shift_q, rx_data};
                        word_cnt_d = word_inc;
                        if (word_inc == len_q) state_d = S_CSUM;
                    end else begin
                        shift_d = {shift_q[WIDTH-17:0], rx_data};
                    end
                end
            end
            S_CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                if (accept && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q    <= S_SYNC;
            run_q      <= 1'b0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // run_q keeps rx_ready low during reset and for the cycle it is released.
    assign rx_ready   = run_q && (state_q != S_DONE);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign cpu_rstn   = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign word_count = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, garbage, bad lengths, valid gaps, mid-frame reset, full 64-word load.
module tb_imem_loader;

    logic       clk;
    logic       arstn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       imem_we;
    logic [5:0] imem_addr;
    logic [31:0] imem_wdata;
    logic       cpu_rstn;
    logic       done;
    logic       err;
    logic [6:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];

    logic [7:0] good_frame [11] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                    8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    int gap_tab [11] = '{0, 2, 0, 1, 3, 0, 0, 2, 1, 0, 1};

    imem_loader #(.WIDTH(32), .ADDR_W(6)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        chk("rx_ready_before_byte", 64'(rx_ready), 64'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        arstn    = 1'b0;
        idle(2);
        arstn = 1'b1;
        idle(1);
        clear_log();
    endtask

    task automatic send_frame(input logic [7:0] last, input bit gapped);
        for (int i = 0; i < 11; i++) begin
            if (gapped) idle(gap_tab[i]);
            if (i == 10) chk("done_before_csum", 64'(done), 64'd0);
            send(i == 10 ? last : good_frame[i]);
        end
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            chk({tag, "_addr0"}, 64'(log_addr[0]), 64'd0);
            chk({tag, "_data0"}, 64'(log_data[0]), 64'h20080005);
            chk({tag, "_addr1"}, 64'(log_addr[1]), 64'd1);
            chk({tag, "_data1"}, 64'(log_data[1]), 64'h2009000A);
        end
    endtask

    task automatic check_good_end(input string tag);
        chk({tag, "_done"},  64'(done),       64'd1);
        chk({tag, "_cpu"},   64'(cpu_rstn),   64'd1);
        chk({tag, "_err"},   64'(err),        64'd0);
        chk({tag, "_wc"},    64'(word_count), 64'd2);
        chk({tag, "_ready"}, 64'(rx_ready),   64'd0);
        check_two_writes(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(rx_ready),   64'd0);
        chk({tag, "_we"},    64'(imem_we),    64'd0);
        chk({tag, "_addr"},  64'(imem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_cpu"},   64'(cpu_rstn),   64'd0);
        chk({tag, "_done"},  64'(done),       64'd0);
        chk({tag, "_err"},   64'(err),        64'd0);
        chk({tag, "_wc"},    64'(word_count), 64'd0);
    endtask

    function automatic logic [31:0] word64(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'h5A, ~b, 8'(i * 7)};
    endfunction

    initial begin
        logic [7:0]  csum;
        logic [31:0] w;

        arstn    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        check_all_zero("reset");
        arstn = 1'b1;
        idle(1);
        chk("ready_after_release", 64'(rx_ready), 64'd1);

        // Scenario 1: good frame back-to-back
        clear_log();
        send_frame(8'h0E, 1'b0);
        check_good_end("good");

        // Scenario 2: bad checksum, then good frame recovers from ERR
        do_reset();
        send_frame(8'h0F, 1'b0);
        chk("badcs_err",  64'(err),        64'd1);
        chk("badcs_cpu",  64'(cpu_rstn),   64'd0);
        chk("badcs_done", 64'(done),       64'd0);
        chk("badcs_wc",   64'(word_count), 64'd2);
        check_two_writes("badcs");
        clear_log();
        send(8'hA5);
        chk("recover_err_clear", 64'(err), 64'd0);
        for (int i = 1; i < 11; i++) send(good_frame[i]);
        check_good_end("recover");

        // Scenario 3: leading garbage
        do_reset();
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        idle(1);
        chk("garbage_nwrites", 64'(log_addr.size()), 64'd0);
        send_frame(8'h0E, 1'b0);
        check_good_end("garbage");

        // Scenario 4: zero and oversize length
        do_reset();
        send(8'hA5);
        send(8'h00);
        chk("len0_err", 64'(err), 64'd1);
        idle(2);
        chk("len0_nwrites", 64'(log_addr.size()), 64'd0);
        chk("len0_wc",      64'(word_count),      64'd0);
        do_reset();
        send(8'hA5);
        chk("len41_err_before", 64'(err), 64'd0);
        send(8'h41);
        chk("len41_err", 64'(err), 64'd1);
        idle(2);
        chk("len41_nwrites", 64'(log_addr.size()), 64'd0);
        chk("len41_wc",      64'(word_count),      64'd0);

        // Scenario 5: valid gaps, including inside words
        do_reset();
        send_frame(8'h0E, 1'b1);
        check_good_end("gaps");

        // Scenario 6: reset coincident with the 6th byte, then a full 64-word frame
        do_reset();
        for (int i = 0; i < 5; i++) send(i == 0 ? 8'hA5 : (i == 1 ? 8'h40 : 8'(8'h11 * i)));
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        arstn    = 1'b0;
        idle(1);
        rx_valid = 1'b0;
        idle(1);
        check_all_zero("midreset");
        chk("midreset_nwrites", 64'(log_addr.size()), 64'd0);
        arstn = 1'b1;
        idle(1);
        chk("midreset_nwrites_after", 64'(log_addr.size()), 64'd0);

        csum = 8'h00;
        send(8'hA5);
        send(8'd64);
        for (int i = 0; i < 64; i++) begin
            w = word64(i);
            for (int k = 3; k >= 0; k--) begin
                csum = csum ^ w[k*8 +: 8];
                send(w[k*8 +: 8]);
            end
        end
        send(csum);
        chk("full_done", 64'(done),       64'd1);
        chk("full_cpu",  64'(cpu_rstn),   64'd1);
        chk("full_wc",   64'(word_count), 64'd64);
        chk("full_nwrites", 64'(log_addr.size()), 64'd64);
        if (log_addr.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("full_addr%0d", i), 64'(log_addr[i]), 64'(i));
                chk($sformatf("full_data%0d", i), 64'(log_data[i]), 64'(word64(i)));
            end
        end
        idle(3);
        chk("full_hold_done",  64'(done),     64'd1);
        chk("full_hold_ready", 64'(rx_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
